// File: rtl/rdcost_mode_select.sv
// -----------------------------------------------------------------------------
// rdcost_mode_select
//   RD-cost mode decision for the affine motion-estimation path. A decision
//   starts with start_load, which latches the baseline (regular/HEVC) cost.
//   NUM_CAND candidate costs then stream in on rdcost_done pulses while a
//   running minimum is kept. After the last candidate the winner is published
//   as a one-hot mode, a binary index and its cost. Between candidates
//   next_start launches the next candidate engine.
//
// Ports
//   clk          clock, rising-edge
//   rst_n        asynchronous active-low reset
//   start_load   pulse: begin a new decision and sample ref_cost
//   ref_cost     baseline cost, valid with start_load
//   rdcost_done  pulse: rdcost holds the next candidate cost
//   rdcost       candidate cost
//   next_start   pulse: launch the next candidate engine
//   busy         high while candidates are being collected
//   done         one-cycle pulse: decision complete
//   result_valid level: cost_min/mode/best_idx hold a valid decision
//   cost_min     winning cost
//   mode         one-hot winner, bit NUM_CAND = baseline
//   best_idx     binary winner index, NUM_CAND = baseline
//   err_extra    pulse: rdcost_done seen while not collecting
// -----------------------------------------------------------------------------
module rdcost_mode_select #(
    parameter int COST_W   = 21,
    parameter int NUM_CAND = 2,
    parameter int IDX_W    = $clog2(NUM_CAND + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_load,
    input  logic [COST_W-1:0] ref_cost,
    input  logic              rdcost_done,
    input  logic [COST_W-1:0] rdcost,
    output logic              next_start,
    output logic              busy,
    output logic              done,
    output logic              result_valid,
    output logic [COST_W-1:0] cost_min,
    output logic [NUM_CAND:0] mode,
    output logic [IDX_W-1:0]  best_idx,
    output logic              err_extra
);

    localparam int MODE_W = NUM_CAND + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);
    localparam logic [IDX_W-1:0] REF_IDX  = IDX_W'(NUM_CAND);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    // A candidate displaces the baseline on a tie, but never displaces an
    // earlier candidate with an equal cost (lower index keeps the win).
    function automatic logic cand_wins(input logic [COST_W-1:0] cand,
                                       input logic [COST_W-1:0] best,
                                       input logic              best_is_ref);
        return (cand < best) || ((cand == best) && best_is_ref);
    endfunction

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  count_q, count_d;
    logic [COST_W-1:0] best_q, best_d;
    logic [IDX_W-1:0]  best_run_idx_q, best_run_idx_d;
    logic              best_is_ref_q, best_is_ref_d;
    logic              next_start_q, next_start_d;
    logic              done_q, done_d;
    logic              result_valid_q, result_valid_d;
    logic [COST_W-1:0] cost_min_q, cost_min_d;
    logic [NUM_CAND:0] mode_q, mode_d;
    logic [IDX_W-1:0]  best_idx_q, best_idx_d;
    logic              err_extra_q, err_extra_d;

    logic              take;
    logic [COST_W-1:0] win_cost;
    logic [IDX_W-1:0]  win_idx;

    always_comb begin
        take     = cand_wins(rdcost, best_q, best_is_ref_q);
        win_cost = take ? rdcost : best_q;
        win_idx  = take ? count_q : best_run_idx_q;

        state_d        = state_q;
        count_d        = count_q;
        best_d         = best_q;
        best_run_idx_d = best_run_idx_q;
        best_is_ref_d  = best_is_ref_q;
        next_start_d   = 1'b0;
        done_d         = 1'b0;
        err_extra_d    = 1'b0;
        result_valid_d = result_valid_q;
        cost_min_d     = cost_min_q;
        mode_d         = mode_q;
        best_idx_d     = best_idx_q;

        // start_load has priority: a coincident candidate is dropped silently.
        if (start_load) begin
            state_d        = COLLECT;
            count_d        = '0;
            best_d         = ref_cost;
            best_run_idx_d = REF_IDX;
            best_is_ref_d  = 1'b1;
            result_valid_d = 1'b0;
        end else if (rdcost_done) begin
            if (state_q == COLLECT) begin
                best_d         = win_cost;
                best_run_idx_d = win_idx;
                best_is_ref_d  = best_is_ref_q && !take;
                if (count_q == LAST_IDX) begin
                    state_d        = IDLE;
                    count_d        = '0;
                    done_d         = 1'b1;
                    result_valid_d = 1'b1;
                    cost_min_d     = win_cost;
                    best_idx_d     = win_idx;
                    mode_d         = MODE_W'(1) << win_idx;
                end else begin
                    count_d      = count_q + IDX_W'(1);
                    next_start_d = 1'b1;
                end
            end else begin
                err_extra_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            count_q        <= '0;
            best_q         <= '0;
            best_run_idx_q <= '0;
            best_is_ref_q  <= 1'b0;
            next_start_q   <= 1'b0;
            done_q         <= 1'b0;
            result_valid_q <= 1'b0;
            cost_min_q     <= '0;
            mode_q         <= '0;
            best_idx_q     <= '0;
            err_extra_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            best_q         <= best_d;
            best_run_idx_q <= best_run_idx_d;
            best_is_ref_q  <= best_is_ref_d;
            next_start_q   <= next_start_d;
            done_q         <= done_d;
            result_valid_q <= result_valid_d;
            cost_min_q     <= cost_min_d;
            mode_q         <= mode_d;
            best_idx_q     <= best_idx_d;
            err_extra_q    <= err_extra_d;
        end
    end

    assign next_start   = next_start_q;
    assign busy         = (state_q == COLLECT);
    assign done         = done_q;
    assign result_valid = result_valid_q;
    assign cost_min     = cost_min_q;
    assign mode         = mode_q;
    assign best_idx     = best_idx_q;
    assign err_extra    = err_extra_q;

endmodule

// File: tb/tb_rdcost_mode_select.sv
// -----------------------------------------------------------------------------
// tb_rdcost_mode_select
//   Two instances: u0 with default parameters (COST_W=21, NUM_CAND=2) and
//   u1 with COST_W=16, NUM_CAND=4. A behavioural model per instance keeps the
//   list of candidates of the open decision and picks the winner as the
//   lowest-index minimum candidate unless the baseline is strictly lower.
//   Every falling edge all outputs of both instances are compared with it.
// -----------------------------------------------------------------------------
module tb_rdcost_mode_select;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        sl [2];
    logic        dn [2];
    logic [20:0] rf [2];
    logic [20:0] rc [2];

    logic        ns0, bz0, dne0, rv0, er0;
    logic [20:0] cm0;
    logic [2:0]  md0;
    logic [1:0]  bi0;
    logic        ns1, bz1, dne1, rv1, er1;
    logic [15:0] cm1;
    logic [4:0]  md1;
    logic [2:0]  bi1;

    rdcost_mode_select u0 (
        .clk(clk), .rst_n(rst_n), .start_load(sl[0]), .ref_cost(rf[0]),
        .rdcost_done(dn[0]), .rdcost(rc[0]), .next_start(ns0), .busy(bz0),
        .done(dne0), .result_valid(rv0), .cost_min(cm0), .mode(md0),
        .best_idx(bi0), .err_extra(er0)
    );

    rdcost_mode_select #(.COST_W(16), .NUM_CAND(4)) u1 (
        .clk(clk), .rst_n(rst_n), .start_load(sl[1]), .ref_cost(rf[1][15:0]),
        .rdcost_done(dn[1]), .rdcost(rc[1][15:0]), .next_start(ns1), .busy(bz1),
        .done(dne1), .result_valid(rv1), .cost_min(cm1), .mode(md1),
        .best_idx(bi1), .err_extra(er1)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int d, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (dut%0d) at %0t: got %0d, expected %0d", nm, d, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int ncand [2] = '{2, 4};
    bit m_active [2];
    int m_ref [2];
    int m_list [2][$];
    bit m_ns [2], m_done [2], m_err [2], m_rv [2];
    int m_cost [2], m_mode [2], m_idx [2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_active[d] = 0; m_list[d].delete();
            m_ns[d] = 0; m_done[d] = 0; m_err[d] = 0; m_rv[d] = 0;
            m_cost[d] = 0; m_mode[d] = 0; m_idx[d] = 0; m_ref[d] = 0;
        end
    endtask

    task automatic model_clock();
        for (int d = 0; d < 2; d++) begin
            m_ns[d] = 0; m_done[d] = 0; m_err[d] = 0;
            if (sl[d]) begin
                m_active[d] = 1;
                m_ref[d] = int'(rf[d]);
                m_list[d].delete();
                m_rv[d] = 0;
            end else if (dn[d]) begin
                if (!m_active[d]) begin
                    m_err[d] = 1;
                end else begin
                    m_list[d].push_back(int'(rc[d]));
                    if (m_list[d].size() == ncand[d]) begin
                        int mn, k;
                        mn = m_list[d][0]; k = 0;
                        for (int j = 1; j < ncand[d]; j++)
                            if (m_list[d][j] < mn) begin mn = m_list[d][j]; k = j; end
                        if (m_ref[d] < mn) begin
                            m_idx[d] = ncand[d]; m_cost[d] = m_ref[d];
                        end else begin
                            m_idx[d] = k; m_cost[d] = mn;
                        end
                        m_mode[d] = 1 << m_idx[d];
                        m_done[d] = 1; m_rv[d] = 1; m_active[d] = 0;
                    end else begin
                        m_ns[d] = 1;
                    end
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_clock();
        end
    end

    // ---------------- per-cycle comparison ----------------
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk("next_start",   d, d ? int'(ns1)  : int'(ns0),  int'(m_ns[d]));
                chk("busy",         d, d ? int'(bz1)  : int'(bz0),  int'(m_active[d]));
                chk("done",         d, d ? int'(dne1) : int'(dne0), int'(m_done[d]));
                chk("err_extra",    d, d ? int'(er1)  : int'(er0),  int'(m_err[d]));
                chk("result_valid", d, d ? int'(rv1)  : int'(rv0),  int'(m_rv[d]));
                chk("cost_min",     d, d ? int'(cm1)  : int'(cm0),  m_cost[d]);
                chk("mode",         d, d ? int'(md1)  : int'(md0),  m_mode[d]);
                chk("best_idx",     d, d ? int'(bi1)  : int'(bi0),  m_idx[d]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int d, input bit s, input int r, input bit v, input int c);
        sl[d] = s; rf[d] = 21'(r); dn[d] = v; rc[d] = 21'(c);
        step();
        sl[d] = 0; dn[d] = 0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin sl[d] = 0; dn[d] = 0; rf[d] = 0; rc[d] = 0; end
        step(); step();
        chk("reset done", 0, int'(dne0), 0);
        chk("reset mode", 0, int'(md0), 0);
        chk("reset busy", 1, int'(bz1), 0);
        rst_n = 1'b1;
        step();

        // T1
        put(0, 1, 500, 0, 0);
        put(0, 0, 0, 1, 300);
        chk("T1 next_start", 0, int'(ns0), 1);
        put(0, 0, 0, 1, 400);
        chk("T1 done", 0, int'(dne0), 1);
        chk("T1 mode", 0, int'(md0), 1);
        chk("T1 cost", 0, int'(cm0), 300);
        chk("T1 idx", 0, int'(bi0), 0);
        chk("T1 model cost", 0, m_cost[0], 300);
        step();
        chk("T1 done pulse", 0, int'(dne0), 0);
        chk("T1 hold", 0, int'(cm0), 300);

        // T2
        put(0, 1, 200, 0, 0);
        put(0, 0, 0, 1, 200);
        put(0, 0, 0, 1, 200);
        chk("T2a mode", 0, int'(md0), 1);
        chk("T2a cost", 0, int'(cm0), 200);
        chk("T2a model mode", 0, m_mode[0], 1);
        put(0, 1, 100, 0, 0);
        put(0, 0, 0, 1, 150);
        put(0, 0, 0, 1, 120);
        chk("T2b mode", 0, int'(md0), 4);
        chk("T2b idx", 0, int'(bi0), 2);
        chk("T2b cost", 0, int'(cm0), 100);
        chk("T2b model idx", 0, m_idx[0], 2);

        // T3
        put(0, 1, 50, 0, 0);
        put(0, 0, 0, 1, 40);
        put(0, 1, 60, 1, 55);
        chk("T3 no err", 0, int'(er0), 0);
        chk("T3 no done", 0, int'(dne0), 0);
        put(0, 0, 0, 1, 70);
        put(0, 0, 0, 1, 10);
        chk("T3 mode", 0, int'(md0), 2);
        chk("T3 cost", 0, int'(cm0), 10);

        // T4
        step();
        put(0, 0, 0, 1, 7);
        chk("T4 err", 0, int'(er0), 1);
        chk("T4 rv held", 0, int'(rv0), 1);
        chk("T4 cost held", 0, int'(cm0), 10);
        step();
        chk("T4 err pulse", 0, int'(er0), 0);

        // T5
        put(1, 1, 2, 0, 0);
        put(1, 0, 0, 1, 16'hFFFF);
        chk("T5 ns1", 1, int'(ns1), 1);
        put(1, 0, 0, 1, 3);
        chk("T5 ns2", 1, int'(ns1), 1);
        put(1, 0, 0, 1, 3);
        chk("T5 ns3", 1, int'(ns1), 1);
        put(1, 0, 0, 1, 1);
        chk("T5 ns last", 1, int'(ns1), 0);
        chk("T5 mode", 1, int'(md1), 8);
        chk("T5 idx", 1, int'(bi1), 3);
        chk("T5 cost", 1, int'(cm1), 1);
        chk("T5 model mode", 1, m_mode[1], 8);

        // T6
        put(0, 1, 80, 0, 0);
        put(0, 0, 0, 1, 30);
        rst_n = 1'b0;
        #1;
        chk("T6 async rv", 0, int'(rv0), 0);
        chk("T6 async cost", 0, int'(cm0), 0);
        chk("T6 async busy", 0, int'(bz0), 0);
        chk("T6 async mode1", 1, int'(md1), 0);
        step();
        rst_n = 1'b1;
        step();
        put(0, 0, 0, 1, 20);
        chk("T6 no done", 0, int'(dne0), 0);
        chk("T6 err", 0, int'(er0), 1);
        step();

        // randomized traffic on both instances
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int d = 0; d < 2; d++) begin
                int mask;
                mask = d ? 32'hFFFF : 32'h1FFFFF;
                sl[d] = ($urandom % 12) == 0;
                dn[d] = ($urandom % 2) == 0;
                rf[d] = 21'((($urandom % 6) == 0) ? ($urandom & mask) : $urandom_range(0, 7));
                rc[d] = 21'((($urandom % 6) == 0) ? ($urandom & mask) : $urandom_range(0, 7));
            end
            if (($urandom % 700) == 0) rst_n = 1'b0;
            else                      rst_n = 1'b1;
            step();
        end
        for (int d = 0; d < 2; d++) begin sl[d] = 0; dn[d] = 0; end
        rst_n = 1'b1;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
